// File: rtl/proc_hier.sv
// proc_hier: single-cycle 16-bit WISC-SP13 subset core with private instruction/data memories.
// Macro CYCLE_COUNT_EN builds the free-running cycle counter; otherwise cycle_count is tied to 0.
module proc_hier #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_we,
    input  logic [15:0] imem_addr,
    input  logic [15:0] imem_wdata,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        reg_write,
    output logic [2:0]  write_reg,
    output logic [15:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        halt,
    output logic        err,
    output logic [31:0] cycle_count
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_RTYP = 5'b11011;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_J    = 5'b00100;

    logic [15:0] imem_q [IMEM_DEPTH];
    logic [15:0] dmem_q [DMEM_DEPTH];
    logic [15:0] rf_q   [8];
    logic [15:0] pc_q, pc_d;
    logic        halt_q;

    logic [15:0] inst_s;
    logic [4:0]  op_s;
    logic [2:0]  rs_idx_s, rt_idx_s;
    logic [15:0] rs_val_s, rt_val_s;
    logic [15:0] imm5_s, imm8_s, imm11_s;
    logic [15:0] pc_inc_s, ea_s, ld_data_s;

    logic        rw_s, mr_s, mw_s, halt_op_s, err_s;
    logic [2:0]  wr_idx_s;
    logic [15:0] wdata_s, maddr_s, mwdata_s;
    logic        unused_s;

    assign inst_s    = imem_q[pc_q[IAW:1]];
    assign op_s      = inst_s[15:11];
    assign rs_idx_s  = inst_s[10:8];
    assign rt_idx_s  = inst_s[7:5];
    assign rs_val_s  = rf_q[rs_idx_s];
    assign rt_val_s  = rf_q[rt_idx_s];
    assign imm5_s    = {{11{inst_s[4]}}, inst_s[4:0]};
    assign imm8_s    = {{8{inst_s[7]}}, inst_s[7:0]};
    assign imm11_s   = {{5{inst_s[10]}}, inst_s[10:0]};
    assign pc_inc_s  = pc_q + 16'd2;
    assign ea_s      = rs_val_s + imm5_s;
    assign ld_data_s = dmem_q[ea_s[DAW:1]];
    assign unused_s  = ^{imem_addr[15:IAW+1], imem_addr[0]};

    // Instruction decode and execute: next pc plus the raw (ungated) write intents.
    always_comb begin
        pc_d      = pc_inc_s;
        rw_s      = 1'b0;
        wr_idx_s  = 3'd0;
        wdata_s   = 16'd0;
        mr_s      = 1'b0;
        mw_s      = 1'b0;
        maddr_s   = 16'd0;
        mwdata_s  = 16'd0;
        halt_op_s = 1'b0;
        err_s     = 1'b0;
        case (op_s)
            OP_HALT: begin
                halt_op_s = 1'b1;
                pc_d      = pc_q;
            end
            OP_NOP: pc_d = pc_inc_s;
            OP_ADDI: begin
                rw_s     = 1'b1;
                wr_idx_s = rt_idx_s;
                wdata_s  = ea_s;
            end
            OP_ST: begin
                mw_s     = 1'b1;
                maddr_s  = ea_s;
                mwdata_s = rt_val_s;
            end
            OP_LD: begin
                mr_s     = 1'b1;
                maddr_s  = ea_s;
                rw_s     = 1'b1;
                wr_idx_s = rt_idx_s;
                wdata_s  = ld_data_s;
            end
            // Store uses the pre-update base; the base register takes the effective address.
            OP_STU: begin
                mw_s     = 1'b1;
                maddr_s  = ea_s;
                mwdata_s = rt_val_s;
                rw_s     = 1'b1;
                wr_idx_s = rs_idx_s;
                wdata_s  = ea_s;
            end
            OP_RTYP: begin
                rw_s     = 1'b1;
                wr_idx_s = inst_s[4:2];
                case (inst_s[1:0])
                    2'b00:   wdata_s = rs_val_s + rt_val_s;
                    2'b01:   wdata_s = rt_val_s - rs_val_s;
                    2'b10:   wdata_s = rs_val_s ^ rt_val_s;
                    2'b11:   wdata_s = rs_val_s & ~rt_val_s;
                    default: wdata_s = 16'd0;
                endcase
            end
            OP_LBI: begin
                rw_s     = 1'b1;
                wr_idx_s = rs_idx_s;
                wdata_s  = imm8_s;
            end
            OP_BEQZ: begin
                if (rs_val_s == 16'd0) pc_d = pc_inc_s + imm8_s;
                else                   pc_d = pc_inc_s;
            end
            OP_BNEZ: begin
                if (rs_val_s != 16'd0) pc_d = pc_inc_s + imm8_s;
                else                   pc_d = pc_inc_s;
            end
            OP_J:    pc_d = pc_inc_s + imm11_s;
            default: err_s = 1'b1;
        endcase
    end

    // Trace outputs: write strobes are suppressed while reset is held.
    always_comb begin
        pc         = pc_q;
        inst       = inst_s;
        reg_write  = rst & rw_s;
        write_reg  = 3'd0;
        write_data = 16'd0;
        if (reg_write) begin
            write_reg  = wr_idx_s;
            write_data = wdata_s;
        end else begin
            write_reg  = 3'd0;
            write_data = 16'd0;
        end
        mem_read   = rst & mr_s;
        mem_write  = rst & mw_s;
        mem_addr   = maddr_s;
        mem_wdata  = mwdata_s;
        halt       = rst & (halt_q | halt_op_s);
        err        = err_s;
    end

    // Program counter and sticky halt flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= 16'd0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_q | halt_op_s;
        end
    end

    // Instruction memory load port; only usable while the core is in reset.
    always_ff @(posedge clk) begin
        if (!rst && imem_we) begin
            imem_q[imem_addr[IAW:1]] <= imem_wdata;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_rf
        // One register-file word, cleared by reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rf_q[g] <= 16'd0;
            end else if (reg_write && (write_reg == 3'(g))) begin
                rf_q[g] <= write_data;
            end
        end
    end

    for (genvar g = 0; g < DMEM_DEPTH; g++) begin : g_dmem
        // One data-memory word, cleared by reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dmem_q[g] <= 16'd0;
            end else if (mem_write && (mem_addr[DAW:1] == DAW'(g))) begin
                dmem_q[g] <= mem_wdata;
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    // Cycle counter: runs out of reset, freezes once halt is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 32'd0;
        end else if (!halt) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_proc_hier.sv
// Directed bench for proc_hier: hand-assembled programs with hand-computed trace values.
module tb_proc_hier;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [15:0] imem_addr, imem_wdata;
    logic [15:0] pc, inst, write_data, mem_addr, mem_wdata;
    logic [2:0]  write_reg;
    logic        reg_write, mem_read, mem_write, halt, err;
    logic [31:0] cycle_count;

    int errors = 0;
    int checks = 0;

    proc_hier dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .pc(pc), .inst(inst), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .halt(halt), .err(err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cc_exp(input logic [31:0] n);
`ifdef CYCLE_COUNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        imem_addr  = a;
        imem_wdata = d;
        imem_we    = 1'b1;
        @(posedge clk);
        #1;
        imem_we    = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem_we = 1'b0; imem_addr = 16'd0; imem_wdata = 16'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_cc", cycle_count, 32'h0);

        // ALU program
        load(16'h0000, 16'hC105);
        load(16'h0002, 16'hC2FD);
        load(16'h0004, 16'hD94C);
        load(16'h0006, 16'h0000);
        chk("rst_gate_rw", 32'(reg_write), 32'h0);
        release_reset();
        chk("c0_pc", 32'(pc), 32'h0);
        chk("c0_inst", 32'(inst), 32'hC105);
        chk("c0_wr", 32'({reg_write, write_reg, write_data}), 32'({1'b1, 3'd1, 16'h0005}));
        chk("c0_maddr", 32'(mem_addr), 32'h0);
        step();
        chk("c1_wdata", 32'(write_data), 32'hFFFD);
        step();
        chk("c2_wr", 32'({reg_write, write_reg, write_data}), 32'({1'b1, 3'd3, 16'h0002}));
        chk("c2_pc", 32'(pc), 32'h0004);
        chk("c2_cc", cycle_count, cc_exp(32'd2));
        step();
        chk("c3_halt", 32'(halt), 32'h1);
        chk("c3_pc", 32'(pc), 32'h0006);
        chk("c3_idle", 32'({reg_write, write_reg, write_data, mem_write}), 32'h0);
        chk("c3_cc", cycle_count, cc_exp(32'd3));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_hold", 32'({halt, pc, reg_write, mem_write}), 32'({1'b1, 16'h0006, 2'b00}));
        end
        chk("halt_cc_frozen", cycle_count, cc_exp(32'd3));
        #2 rst = 1'b0;
        #1;
        chk("async_pc", 32'(pc), 32'h0);
        chk("async_halt", 32'(halt), 32'h0);
        chk("async_cc", cycle_count, 32'h0);

        // Store/load and remaining ALU ops
        load(16'h0000, 16'hC110);
        load(16'h0002, 16'hC27F);
        load(16'h0004, 16'h8142);
        load(16'h0006, 16'h8982);
        load(16'h0008, 16'hD955);
        load(16'h000A, 16'hDD5A);
        load(16'h000C, 16'hDD5F);
        load(16'h000E, 16'h427F);
        load(16'h0010, 16'hF800);
        load(16'h0012, 16'h0000);
        release_reset();
        step();
        step();
        chk("st_mw", 32'({mem_write, reg_write, mem_read}), 32'b100);
        chk("st_addr", 32'(mem_addr), 32'h0012);
        chk("st_wdata", 32'(mem_wdata), 32'h007F);
        step();
        chk("ld_mr", 32'({mem_read, mem_write}), 32'b10);
        chk("ld_wr", 32'({reg_write, write_reg, write_data}), 32'({1'b1, 3'd4, 16'h007F}));
        step();
        chk("sub", 32'({write_reg, write_data}), 32'({3'd5, 16'h006F}));
        step();
        chk("xor", 32'({write_reg, write_data}), 32'({3'd6, 16'h0010}));
        step();
        chk("andn", 32'({write_reg, write_data}), 32'({3'd7, 16'h0000}));
        step();
        chk("addi", 32'({write_reg, write_data}), 32'({3'd3, 16'h007E}));
        step();
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_pc", 32'(pc), 32'h0010);
        chk("ill_idle", 32'({reg_write, mem_write, mem_read, write_reg, write_data, mem_addr}), 32'h0);
        step();
        chk("ill_next", 32'({halt, err, pc}), 32'({1'b1, 1'b0, 16'h0012}));
        enter_reset();

        // STU
        load(16'h0000, 16'hC120);
        load(16'h0002, 16'hC255);
        load(16'h0004, 16'h995E);
        load(16'h0006, 16'h8960);
        load(16'h0008, 16'h0000);
        release_reset();
        step();
        step();
        chk("stu_mem", 32'({mem_write, mem_addr}), 32'({1'b1, 16'h001E}));
        chk("stu_wdata", 32'(mem_wdata), 32'h0055);
        chk("stu_reg", 32'({reg_write, write_reg, write_data}), 32'({1'b1, 3'd1, 16'h001E}));
        step();
        chk("stu_ld", 32'({mem_addr, write_data}), 32'({16'h001E, 16'h0055}));
        enter_reset();

        // Branches and jump (r1 cleared by reset, jump word loaded through a wrapped address)
        load(16'h0000, 16'h6104);
        load(16'h0006, 16'h6804);
        load(16'h0208, 16'h27FC);
        release_reset();
        step();
        chk("beqz_taken", 32'(pc), 32'h0006);
        step();
        chk("bnez_not", 32'(pc), 32'h0008);
        chk("wrap_inst", 32'(inst), 32'h27FC);
        step();
        chk("j_back", 32'(pc), 32'h0006);
        chk("br_noerr", 32'({err, reg_write, mem_write}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
